// File: rtl/sensor_responder.sv
// Polled/alarm sensor responder: answers a matching request byte (or an alarm
// crossing) with a two-byte frame {value, value ^ CHECK_KEY} and then holds off for a gap.
module sensor_responder #(
    parameter logic [7:0]  SENSOR_ID   = 8'h01,
    parameter logic [7:0]  CHECK_KEY   = 8'h37,
    parameter logic [7:0]  ALARM_LIMIT = 8'hC8,
    parameter int unsigned REPLY_GAP   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       tx_done,
    input  logic [7:0] sample,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       alarm,
    output logic       drop
);

    localparam int GW = (REPLY_GAP > 1) ? $clog2(REPLY_GAP + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, SEND_VAL, WAIT_VAL, SEND_CHK, WAIT_CHK, GAP
    } state_t;

    state_t        state;
    logic [7:0]    value;
    logic [GW-1:0] gap_cnt;

    logic req_hit, alarm_hit;
    assign req_hit   = rx_dv && (rx_byte == SENSOR_ID);
    assign alarm_hit = (sample > ALARM_LIMIT) && !alarm;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
            alarm   <= 1'b0;
            drop    <= 1'b0;
            value   <= 8'h00;
            gap_cnt <= '0;
        end else begin
            tx_dv <= 1'b0;
            drop  <= 1'b0;
            // Re-arm is independent of the frame in flight.
            if (sample <= ALARM_LIMIT)
                alarm <= 1'b0;
            if (req_hit && state != IDLE)
                drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_hit || alarm_hit) begin
                        value <= sample;
                        state <= SEND_VAL;
                        if (alarm_hit)
                            alarm <= 1'b1;
                    end
                end
                SEND_VAL: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= value;
                    state   <= WAIT_VAL;
                end
                WAIT_VAL: if (tx_done) state <= SEND_CHK;
                SEND_CHK: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= value ^ CHECK_KEY;
                    state   <= WAIT_CHK;
                end
                WAIT_CHK: begin
                    if (tx_done) begin
                        gap_cnt <= GW'(REPLY_GAP);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // Counter spends one cycle at zero, so the gap is REPLY_GAP+1 cycles.
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder; the bench plays the UART and strobes tx_done.
module tb_sensor_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       busy;
    logic       alarm;
    logic       drop;

    int n_chk = 0;
    int n_fail = 0;
    int tx_cnt = 0;
    int drop_cnt = 0;

    sensor_responder #(
        .SENSOR_ID(8'h01), .CHECK_KEY(8'h37), .ALARM_LIMIT(8'hC8), .REPLY_GAP(16)
    ) dut (
        .clock(clock), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_done(tx_done), .sample(sample), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .busy(busy), .alarm(alarm), .drop(drop)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && tx_dv) tx_cnt <= tx_cnt + 1;
        if (reset && drop)  drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 50 && !tx_dv; i++) tick();
        chk({tag, "_dv"}, 32'(tx_dv), 32'd1);
        chk({tag, "_byte"}, 32'(tx_byte), 32'(exp));
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) tick();
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic request(input logic [7:0] id);
        rx_dv = 1'b1;
        rx_byte = id;
        tick();
        rx_dv = 1'b0;
    endtask

    initial begin
        int n, t0, d0;
        #2;
        chk("rst_tx_dv", 32'(tx_dv), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic poll: exact 2-cycle latency, checksum, gap length
        sample = 8'h2A;
        request(8'h01);
        chk("lat_c1_dv", 32'(tx_dv), 32'd0);
        chk("lat_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_c2_dv", 32'(tx_dv), 32'd1);
        chk("val_byte", 32'(tx_byte), 32'h2A);
        tick();
        chk("val_one_cycle", 32'(tx_dv), 32'd0);
        chk("val_hold", 32'(tx_byte), 32'h2A);
        pulse_done();
        wait_tx("chk_2a", 8'h1D);
        tick();
        pulse_done();
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("gap_len", 32'(n), 32'd17);

        // Foreign ID and broadcast zero are ignored in IDLE
        t0 = tx_cnt; d0 = drop_cnt;
        request(8'h05);
        request(8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("ign_tx", 32'(tx_cnt - t0), 32'd0);
        chk("ign_drop", 32'(drop_cnt - d0), 32'd0);
        chk("ign_busy", 32'(busy), 32'd0);

        // Unsolicited alarm frame, latch, re-arm, second alarm frame
        sample = 8'hD0;
        wait_tx("alm1_val", 8'hD0);
        chk("alm1_alarm", 32'(alarm), 32'd1);
        tick(); pulse_done();
        wait_tx("alm1_chk", 8'hE7);
        tick(); pulse_done();
        wait_idle("alm1_idle");
        t0 = tx_cnt;
        for (int i = 0; i < 30; i++) tick();
        chk("alm_latched_notx", 32'(tx_cnt - t0), 32'd0);
        chk("alm_latched_alarm", 32'(alarm), 32'd1);
        sample = 8'h10;
        tick(); tick();
        chk("alm_rearm", 32'(alarm), 32'd0);
        sample = 8'hD0;
        wait_tx("alm2_val", 8'hD0);
        tick(); pulse_done();
        wait_tx("alm2_chk", 8'hE7);
        tick(); pulse_done();
        wait_idle("alm2_idle");
        sample = 8'h00;
        tick(); tick();

        // Request during WAIT_VAL is dropped, frame unchanged
        t0 = tx_cnt; d0 = drop_cnt;
        sample = 8'h55;
        request(8'h01);
        wait_tx("drp_val", 8'h55);
        tick();
        sample = 8'h99;
        rx_dv = 1'b1; rx_byte = 8'h01;
        tick();
        rx_dv = 1'b0;
        chk("drp_pulse", 32'(drop), 32'd1);
        tick();
        chk("drp_one_cycle", 32'(drop), 32'd0);
        pulse_done();
        wait_tx("drp_chk", 8'h62);
        tick(); pulse_done();
        wait_idle("drp_idle");
        for (int i = 0; i < 5; i++) tick();
        chk("drp_tx_count", 32'(tx_cnt - t0), 32'd2);
        chk("drp_drop_count", 32'(drop_cnt - d0), 32'd1);

        // Reset in WAIT_CHK abandons the frame
        sample = 8'h33;
        request(8'h01);
        wait_tx("rst_mid_val", 8'h33);
        tick(); pulse_done();
        wait_tx("rst_mid_chk", 8'h04);
        tick();
        t0 = tx_cnt;
        reset = 1'b0;
        #1;
        chk("rstm_tx_dv", 32'(tx_dv), 32'd0);
        chk("rstm_tx_byte", 32'(tx_byte), 32'h00);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_alarm", 32'(alarm), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        pulse_done();
        for (int i = 0; i < 10; i++) tick();
        chk("rstm_no_tx", 32'(tx_cnt - t0), 32'd0);
        chk("rstm_idle", 32'(busy), 32'd0);

        // Request and alarm in the same IDLE cycle -> one frame
        t0 = tx_cnt;
        sample = 8'hFF;
        request(8'h01);
        tick();
        chk("both_dv", 32'(tx_dv), 32'd1);
        chk("both_val", 32'(tx_byte), 32'hFF);
        chk("both_alarm", 32'(alarm), 32'd1);
        tick(); pulse_done();
        wait_tx("both_chk", 8'hC8);
        tick(); pulse_done();
        wait_idle("both_idle");
        for (int i = 0; i < 20; i++) tick();
        chk("both_tx_count", 32'(tx_cnt - t0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 Parameter SENSOR_ID, default 8'h01, request byte this sensor answers to.
REQ-002 Parameter CHECK_KEY, default 8'h37, XOR key for the checksum byte.
REQ-003 Parameter ALARM_LIMIT, default 8'hC8, sample strictly above this raises an alarm.
REQ-004 Parameter REPLY_GAP, default 16, idle clocks enforced between checksum tx_done and the next frame.
REQ-005 clock  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rx_dv  input  1  one-cycle strobe, rx_byte valid (from uart_rx).
REQ-008 rx_byte  input  8  received request byte.
REQ-009 tx_done  input  1  one-cycle strobe, current byte fully sent (from uart_tx).
REQ-010 sample  input  8  live sensor reading.
REQ-011 tx_dv  output  1  one-cycle strobe, start transmitting tx_byte.
REQ-012 tx_byte  output  8  byte to transmit; stable from tx_dv until matching tx_done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 alarm  output  1  high while an alarm is latched (reported, not yet re-armed).
REQ-015 drop  output  1  one-cycle pulse when a request is discarded because busy is high.

Function
REQ-016 States SHALL be IDLE, SEND_VAL, WAIT_VAL, SEND_CHK, WAIT_CHK, GAP.
REQ-017 In IDLE, rx_dv with rx_byte == SENSOR_ID SHALL latch sample into a value register and go to SEND_VAL next cycle.
REQ-018 In IDLE, rx_dv with rx_byte == 8'h00 or any other ID SHALL be ignored: no state change, no drop pulse.
REQ-019 In IDLE with no matching request, sample > ALARM_LIMIT while alarm is low SHALL latch sample, set alarm, and go to SEND_VAL (unsolicited frame).
REQ-020 A matching request and an alarm condition in the same IDLE cycle SHALL produce one frame only; alarm SHALL still be set.
REQ-021 SEND_VAL SHALL assert tx_dv for exactly one cycle with tx_byte = value, then go to WAIT_VAL.
REQ-022 WAIT_VAL SHALL hold until tx_done, then go to SEND_CHK.
REQ-023 SEND_CHK SHALL assert tx_dv for one cycle with tx_byte = value XOR CHECK_KEY, then go to WAIT_CHK.
REQ-024 WAIT_CHK SHALL hold until tx_done, then load the gap counter with REPLY_GAP and go to GAP.
REQ-025 GAP SHALL decrement each cycle and return to IDLE on the cycle after the counter reaches 0; REPLY_GAP = 0 SHALL return on the next cycle.
REQ-026 Frame byte order SHALL be value first, checksum second; no other bytes are sent.
REQ-027 Any rx_dv with rx_byte == SENSOR_ID outside IDLE SHALL pulse drop and be otherwise ignored (not queued).
REQ-028 alarm SHALL clear (re-arm) in any state on the first cycle sample <= ALARM_LIMIT; it SHALL NOT abort a frame in progress.
REQ-029 tx_done in IDLE, SEND_VAL, SEND_CHK or GAP SHALL be ignored.
REQ-030 Latency from matching rx_dv to first tx_dv SHALL be exactly 2 cycles.

Reset
REQ-031 reset low SHALL immediately force IDLE, tx_dv=0, tx_byte=8'h00, busy=0, alarm=0, drop=0, value=0, gap counter=0.
REQ-032 reset asserted mid-frame SHALL abandon the frame; after release no remaining byte is sent.
REQ-033 First action after reset release SHALL be evaluated on the first rising clock edge with reset high.

Verification
REQ-034 sample=8'h2A, rx_byte=8'h01 strobe -> tx_dv with 8'h2A two cycles later, after tx_done tx_dv with 8'h1D, busy low REPLY_GAP+1 cycles after second tx_done.
REQ-035 rx_byte=8'h05 and 8'h00 strobes in IDLE -> no tx_dv, no drop, busy stays 0.
REQ-036 sample stepped to 8'hD0 -> unsolicited frame 8'hD0, 8'hE7; alarm=1; no second frame while sample stays 8'hD0; sample=8'h10 then 8'hD0 again -> alarm clears then a new frame is sent.
REQ-037 Matching request during WAIT_VAL -> drop pulses once, current frame completes unchanged, no second frame.
REQ-038 reset pulled low in WAIT_CHK -> all outputs at reset values at once; after release and tx_done strobe, no tx_dv.
REQ-039 Matching request and sample=8'hFF in same IDLE cycle -> exactly one frame 8'hFF, 8'hC8; alarm=1.
